// File: rtl/serial_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : serial_tx_pkg
//  Purpose : Shared types and constants for the serial_tx_paridade transmitter.
//            Holds the frame FSM state encoding, the frame/data bit counts and
//            a helper that sizes the baud counter.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package serial_tx_pkg;

    // Start + 8 data + parity + stop
    localparam int FRAME_BITS = 11;
    localparam int DATA_BITS  = 8;
    localparam int IDX_W      = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Counter width for a 0..n-1 counter; a single-cycle bit still needs one
    // flop so the counter has a legal, non-zero width.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_tx_paridade_gerador_baud.sv
`default_nettype none
// ============================================================================
//  Module  : gerador_baud
//  Purpose : Bit-period timer. Counts 0..CLKS_PER_BIT-1 while enabled and
//            flags the last cycle of each bit period. Held at zero while
//            disabled so every frame starts with a full-length first bit.
//  Ports   : clk      - system clock, rising edge
//            rst      - synchronous active-high reset
//            enable   - count while high, clear while low
//            bit_tick - high on the final cycle of a bit period
//  Rev     : 1.0  initial release
// ============================================================================
module gerador_baud
    import serial_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic bit_tick
);

    localparam int unsigned CNT_W = cnt_width(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!enable || (cnt_q == LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_tick = enable && (cnt_q == LAST);

endmodule
`default_nettype wire

// File: rtl/serial_tx_paridade.sv
`default_nettype none
// ============================================================================
//  Module  : serial_tx_paridade
//  Purpose : UART-style transmitter for a byte plus upstream parity. Frame is
//            start(0), 8 data bits LSB first, parity, stop(1); each bit held
//            CLKS_PER_BIT cycles. All outputs are registered.
//  Ports   : clk        - system clock, rising edge
//            rst        - synchronous active-high reset
//            data_in    - byte to transmit
//            parity_in  - even parity of data_in
//            valid_in   - data_in/parity_in valid
//            ready_out  - byte can be accepted this cycle
//            tx_out     - serial line, idle high
//            busy_out   - frame in progress
//            frame_done - one-cycle pulse after the stop bit completes
//  Rev     : 1.0  initial release
// ============================================================================
module serial_tx_paridade
    import serial_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter bit          PARITY_ODD   = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 parity_in,
    input  logic                 valid_in,
    output logic                 ready_out,
    output logic                 tx_out,
    output logic                 busy_out,
    output logic                 frame_done
);

    state_t               state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q,   par_d;
    logic [IDX_W-1:0]     idx_q,   idx_d;
    logic                 tx_q,    tx_d;
    logic                 ready_q, ready_d;
    logic                 busy_q,  busy_d;
    logic                 done_q,  done_d;
    logic                 bit_tick;

    // The timer runs exactly while a frame is on the line.
    gerador_baud #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .rst      (rst),
        .enable   (busy_q),
        .bit_tick (bit_tick)
    );

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        par_d   = par_q;
        idx_d   = idx_q;
        tx_d    = tx_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (valid_in && ready_q) begin
                    shift_d = data_in;
                    par_d   = parity_in ^ PARITY_ODD;
                    idx_d   = '0;
                    tx_d    = 1'b0;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (bit_tick) begin
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                    idx_d   = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_tick) begin
                    if (idx_q == IDX_W'(DATA_BITS - 1)) begin
                        tx_d    = par_q;
                        state_d = ST_PARITY;
                    end else begin
                        // shift_q[0] already holds the next bit to send
                        tx_d    = shift_q[0];
                        shift_d = shift_q >> 1;
                        idx_d   = idx_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_tick) begin
                    tx_d    = 1'b1;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_tick) begin
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                tx_d    = 1'b1;
                ready_d = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            par_q   <= 1'b0;
            idx_q   <= '0;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign tx_out     = tx_q;
    assign ready_out  = ready_q;
    assign busy_out   = busy_q;
    assign frame_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_tx_paridade.sv
`default_nettype none
// ============================================================================
//  Module  : tb_serial_tx_paridade
//  Purpose : Self-checking bench for serial_tx_paridade. Three instances:
//            0: 4 clk/bit even, 1: 4 clk/bit odd, 2: 1 clk/bit even.
//            A frame-level reference model predicts every output each cycle;
//            table-driven and hand-written sequences add targeted checks.
//  Ports   : none
//  Rev     : 1.0  initial release
// ============================================================================
module tb_serial_tx_paridade;
    import serial_tx_pkg::*;

    localparam int NDUT = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din  [NDUT];
    logic       par  [NDUT];
    logic       vld  [NDUT];
    logic       rdy  [NDUT];
    logic       tx   [NDUT];
    logic       busy [NDUT];
    logic       done [NDUT];

    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < NDUT; g++) begin : g_dut
            localparam int unsigned N   = (g == 2) ? 1 : 4;
            localparam bit          ODD = (g == 1);
            serial_tx_paridade #(
                .CLKS_PER_BIT (N),
                .PARITY_ODD   (ODD)
            ) u_dut (
                .clk        (clk),
                .rst        (rst),
                .data_in    (din[g]),
                .parity_in  (par[g]),
                .valid_in   (vld[g]),
                .ready_out  (rdy[g]),
                .tx_out     (tx[g]),
                .busy_out   (busy[g]),
                .frame_done (done[g])
            );
        end
    endgenerate

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 1'b0;

    function automatic int nclk(input int i);
        return (i == 2) ? 1 : 4;
    endfunction

    function automatic logic odd(input int i);
        return (i == 1);
    endfunction

    task automatic chk(input string nm, input int i, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s dut%0d: got %0d expected %0d at %0t", nm, i, act, exp, $time);
        end
    endtask

    // ---------------- frame-level reference model ----------------
    // ph = 0 when idle, else 1..FRAME_BITS*N = cycle number inside the frame.
    int         ph      [NDUT] = '{default: 0};
    logic [7:0] m_byte  [NDUT] = '{default: 8'h00};
    logic       m_par   [NDUT] = '{default: 1'b0};
    logic       m_done  [NDUT] = '{default: 1'b0};
    int         acc_cyc [NDUT] = '{default: 0};
    int         cyc = 0;

    function automatic logic frame_bit(input int i, input int j);
        if (j == 0)              return 1'b0;
        if (j <= DATA_BITS)      return m_byte[i][j-1];
        if (j == DATA_BITS + 1)  return m_par[i] ^ odd(i);
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        cyc++;
        for (int i = 0; i < NDUT; i++) begin
            m_done[i] = 1'b0;
            if (rst) begin
                ph[i] = 0;
            end else if (ph[i] == 0) begin
                if (vld[i]) begin
                    ph[i]      = 1;
                    m_byte[i]  = din[i];
                    m_par[i]   = par[i];
                    acc_cyc[i] = cyc;
                end
            end else if (ph[i] == FRAME_BITS * nclk(i)) begin
                ph[i]     = 0;
                m_done[i] = 1'b1;
            end else begin
                ph[i]++;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < NDUT; i++) begin
                chk("tx_model",    i, int'(tx[i]),
                    (ph[i] == 0) ? 1 : int'(frame_bit(i, (ph[i] - 1) / nclk(i))));
                chk("ready_model", i, int'(rdy[i]),  int'(ph[i] == 0));
                chk("busy_model",  i, int'(busy[i]), int'(ph[i] != 0));
                chk("done_model",  i, int'(done[i]), int'(m_done[i]));
            end
        end
    end

    // ---------------- stimulus helpers (called at a negedge) ----------------
    task automatic send(input int i, input logic [7:0] b, input logic p, output bit ok);
        din[i] = b;
        par[i] = p;
        vld[i] = 1'b1;
        ok     = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (rdy[i]) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            chk("handshake_timeout", i, 0, 1);
            vld[i] = 1'b0;
        end else begin
            @(posedge clk);
            @(negedge clk);
            vld[i] = 1'b0;
        end
    endtask

    // Sends one byte, samples the first cycle of every bit, then checks the
    // frame_done pulse on the cycle after the frame. Optionally offers a new
    // byte (0x3C) while the frame is in progress.
    task automatic frame(input int i, input logic [7:0] b, input logic p,
                         input logic [10:0] exp, input string nm, input bit inject);
        bit          ok;
        logic [10:0] cap;
        int          n;
        n   = nclk(i);
        cap = '0;
        send(i, b, p, ok);
        if (ok) begin
            for (int c = 1; c <= FRAME_BITS * n; c++) begin
                if (c > 1) @(negedge clk);
                if ((c - 1) % n == 0) cap[(c - 1) / n] = tx[i];
                if (inject && c == 10) begin
                    din[i] = 8'h3C;
                    par[i] = 1'b0;
                    vld[i] = 1'b1;
                end
            end
            chk(nm, i, int'(cap), int'(exp));
            @(negedge clk);
            chk({nm, "_done"}, i, int'(done[i]), 1);
        end
    endtask

    typedef struct {
        int          dut;
        logic [7:0]  data;
        logic        p;
        logic [10:0] exp;   // bit k = k-th bit on the line
    } vec_t;

    vec_t vt [4];

    initial begin
        bit ok;
        int a;

        vt[0] = '{0, 8'hA5, 1'b0, 11'h54A};
        vt[1] = '{1, 8'h07, 1'b1, 11'h40E};
        vt[2] = '{2, 8'hFF, 1'b0, 11'h5FE};
        vt[3] = '{1, 8'h81, 1'b0, 11'h702};

        for (int i = 0; i < NDUT; i++) begin
            din[i] = 8'h00;
            par[i] = 1'b0;
            vld[i] = 1'b0;
        end

        // reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < NDUT; i++) begin
            chk("rst_tx",    i, int'(tx[i]),   1);
            chk("rst_ready", i, int'(rdy[i]),  1);
            chk("rst_busy",  i, int'(busy[i]), 0);
            chk("rst_done",  i, int'(done[i]), 0);
        end
        rst    = 1'b0;
        chk_en = 1'b1;

        // table-driven frames
        for (int k = 0; k < 4; k++) begin
            frame(vt[k].dut, vt[k].data, vt[k].p, vt[k].exp, "frame_bits", 1'b0);
        end

        // valid while busy is ignored; 0x3C goes out after one idle cycle
        frame(0, 8'hA5, 1'b0, 11'h54A, "busy_frame", 1'b1);
        a = acc_cyc[0];
        frame(0, 8'h3C, 1'b0, 11'h478, "after_busy", 1'b0);
        chk("frame_spacing", 0, acc_cyc[0] - a, FRAME_BITS * 4 + 1);

        // reset during DATA bit 3
        send(0, 8'h5A, 1'b0, ok);
        repeat (17) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_tx",    0, int'(tx[0]),   1);
        chk("midrst_ready", 0, int'(rdy[0]),  1);
        chk("midrst_busy",  0, int'(busy[0]), 0);
        chk("midrst_done",  0, int'(done[0]), 0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("midrst_quiet_tx",   0, int'(tx[0]),   1);
            chk("midrst_quiet_done", 0, int'(done[0]), 0);
        end
        frame(0, 8'h81, 1'b0, 11'h502, "post_rst", 1'b0);

        // randomized traffic, checked cycle by cycle by the model
        for (int r = 0; r < 30; r++) begin
            int          i;
            logic [7:0]  b;
            logic        p;
            i = int'($urandom_range(0, NDUT - 1));
            b = 8'($urandom);
            p = 1'($urandom_range(0, 1));
            send(i, b, p, ok);
            repeat ($urandom_range(0, 20)) @(negedge clk);
        end
        repeat (60) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
